// File: rtl/div_if.sv
// Handshake and operand bus between the execute-stage pipeline and the divider.
interface div_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; produces {remainder, quotient}
// for HI/LO after 32 iterations, stalling the pipeline while busy.
module div_unit (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        sign_q, sign_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic [31:0] dvd_mag, dvs_mag;
  logic [65:0] work_sh;
  logic [33:0] trial;
  logic [64:0] work_n;
  logic [31:0] quot, rem;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  assign accept = bus.start_i && !bus.annul_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = (bus.opdata2_i == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_d = bus.annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (bus.annul_i)         state_d = S_IDLE;
        else if (cnt_q == 5'd31) state_d = S_END;
      end
      S_END:     if (!bus.start_i) state_d = S_IDLE;
    endcase
  end

  // One restoring step; the shifted register is one bit wider so the trial
  // subtraction sees the full 33-bit partial remainder plus the borrow.
  always_comb begin
    dvd_mag = mag(bus.opdata1_i, bus.signed_i);
    dvs_mag = mag(op2_q, sign_q);
    work_sh = {work_q, 1'b0};
    trial   = work_sh[65:32] - {2'b00, dvs_mag};
    if (trial[33]) work_n = work_sh[64:0];
    else           work_n = {trial[32:0], work_sh[31:1], 1'b1};
    quot = work_n[31:0];
    rem  = work_n[63:32];
    if (sign_q && (op1_q[31] ^ op2_q[31])) quot = -quot;
    if (sign_q && op1_q[31])               rem  = -rem;
  end

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        result_d = '0;
        if (accept) begin
          op1_d  = bus.opdata1_i;
          op2_d  = bus.opdata2_i;
          sign_d = bus.signed_i;
          cnt_d  = '0;
          work_d = {33'b0, dvd_mag};
        end
      end
      S_DIVZERO: result_d = bus.annul_i ? '0 : {op1_q, 32'hFFFF_FFFF};
      S_ON: begin
        if (bus.annul_i) begin
          result_d = '0;
        end else begin
          work_d = work_n;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) result_d = {rem, quot};
        end
      end
      S_END: if (!bus.start_i) result_d = '0;
    endcase
    ready_d = (state_d == S_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      work_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.stall_o  = bus.start_i && !ready_q && !bus.annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: latency, results, stall, annul and reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input int hold);
    logic [63:0] exp_r;
    int lat, n;
    bit seen, stall_ok;
    sb_q.push_back(model(s, a, b));
    lat = (b == 32'd0) ? 2 : 33;
    bus.signed_i  = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    #1;
    check("stall_start", 64'(bus.stall_o), 64'd1);
    n = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ready_o === 1'b1) seen = 1'b1;
      else begin
        if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
        if (scramble) begin
          bus.opdata1_i = $urandom;
          bus.opdata2_i = $urandom;
          bus.signed_i  = 1'($urandom_range(1));
        end
      end
    end
    exp_r = sb_q.pop_front();
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(lat));
    check("stall_busy", 64'(stall_ok), 64'd1);
    check("result", bus.result_o, exp_r);
    check("stall_ready", 64'(bus.stall_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, exp_r);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(bus.ready_o), 64'd0);
    check("drop_result", bus.result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit any_ready;
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.annul_i   = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7, 1'b0, 0);
    check("divu_100_7", {32'd2, 32'd14}, model(1'b0, 32'd100, 32'd7));
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 1'b0, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_div(1'b1, 32'hDEAD_BEEF, 32'd1234, 1'b1, 0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd0, 1'b0, 5);
    do_div(1'b0, 32'd1000, 32'd3, 1'b0, 6);

    // start with annul in IDLE must be ignored
    bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd0; bus.signed_i = 1'b0;
    bus.start_i = 1'b1; bus.annul_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    any_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) any_ready = 1'b1;
    end
    check("annul_idle_ignored", 64'(any_ready), 64'd0);

    // annul mid-operation
    bus.opdata1_i = 32'h5555_5555; bus.opdata2_i = 32'd3; bus.signed_i = 1'b0;
    bus.start_i = 1'b1;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    #1;
    check("annul_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    check("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    any_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) any_ready = 1'b1;
    end
    check("annul_no_ready", 64'(any_ready), 64'd0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);

    // reset mid-operation
    bus.opdata1_i = 32'h9ABC_DEF0; bus.opdata2_i = 32'h11; bus.signed_i = 1'b0;
    bus.start_i = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1; bus.start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    check("midrst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_div(1'b1, 32'hFFFF_CFC7, 32'd17, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (k[0]) ? 32'($urandom_range(1, 1000)) : $urandom;
      do_div(1'($urandom_range(1)), a, b, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider in the execute stage of the MIPS core. It produces the 64-bit `{remainder, quotient}` word that the writeback path writes into HI/LO for DIV/DIVU. The divider performs one radix-2 restoring iteration per cycle and holds a stall request to the pipeline while it is busy. It supports a flush (annul) from exception handling.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  request a division; held high by the pipeline until `ready_o` is seen
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  32  dividend (rs)
- opdata2_i  input  32  divisor (rt)
- annul_i  input  1  abort the operation in flight (exception/flush)
- result_o  output  64  `[63:32]` remainder (HI), `[31:0]` quotient (LO)
- ready_o  output  1  `result_o` valid
- stall_o  output  1  pipeline stall request

## Operation
- Reset: state IDLE; `result_o`=0, `ready_o`=0, `stall_o`=0; counter, partial remainder and operand registers cleared. `rst` overrides every other input.
- States: IDLE, DIVZERO, ON, END.
- **IDLE**
  - If `start_i`=1 and `annul_i`=0: latch operands and `signed_i`.
  - If divisor = 0, go to DIVZERO. Otherwise go to ON, with counter=0 and the 65-bit work register = `{33'b0, |dividend|}`.
  - `start_i` with `annul_i`=1 is ignored.
- **DIVZERO**: one cycle, then END with `result_o` = `{latched dividend, 32'hFFFF_FFFF}`. This applies to both signed and unsigned.
- **ON**, one iteration per cycle, 32 iterations:
  - Shift the work register left by 1.
  - Trial-subtract `|divisor|` from the upper 33 bits. If the result is non-negative, keep it and set quotient bit 0 to 1. Otherwise restore and set quotient bit 0 to 0.
  - After counter reaches 31, go to END.
- **Signed fix-up** (applied on entry to END):
  - `|x|` is the unsigned two's-complement negation of x when x[31]=1 and signed.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - `0x8000_0000 / 0xFFFF_FFFF` (signed) yields quotient `0x8000_0000`, remainder 0. No trap.
- **END**
  - `ready_o`=1 and `result_o` holds the final value.
  - Stay in END while `start_i`=1.
  - When `start_i`=0, go to IDLE: `ready_o`→0 and `result_o`→0 on that edge.
- **Annul**
  - `annul_i`=1 in DIVZERO or ON: next edge goes to IDLE, `ready_o` stays 0, `result_o`=0.
  - `annul_i` in END is ignored; the consumer discards the result.
- **Operand changes**: changes on `opdata*_i`/`signed_i` after acceptance have no effect.
- **stall_o** = `start_i` & ~`ready_o` & ~`annul_i` (combinational). It deasserts in the cycle `ready_o` is high.

## Timing
- `start_i` sampled at edge E0 (state IDLE):
  - state ON after E0
  - iterations at E1–E32
  - state END after E32
- Normal division: `ready_o` is first high 33 cycles after the first cycle `start_i` is high.
- Divide-by-zero: `ready_o` high 2 cycles after `start_i`.
- `result_o` and `ready_o` are registered and change only on rising edges.
- The writeback stage captures `result_o` in a cycle where `ready_o`=1, so the HI/LO write sees a stable value for the full cycle.
- Back-to-back divisions require at least one cycle with `start_i`=0 (END→IDLE). The next request is accepted at the earliest edge after that.

## Test plan
- **Unsigned basic**: DIVU 100 / 7 with start held → `ready_o` rises exactly 33 cycles after start; `result_o` = `{32'd2, 32'd14}`. Drop start → `ready_o`=0 and `result_o`=0 next cycle.
- **Signed mixed signs**: DIV −7 (`0xFFFF_FFF9`) / 2 → quotient `0xFFFF_FFFD`, remainder `0xFFFF_FFFF`. DIV 7 / −2 → quotient `0xFFFF_FFFD`, remainder 1.
- **Divide-by-zero and overflow**:
  - DIVU `0x1234_5678` / 0 → `ready_o` after 2 cycles; result `{0x1234_5678, 0xFFFF_FFFF}`.
  - DIV `0x8000_0000` / `0xFFFF_FFFF` → `{0, 0x8000_0000}` after 33 cycles.
- **Annul mid-operation**: assert `annul_i` for one cycle at iteration 10 → IDLE next cycle, `ready_o` never asserts, `stall_o` low. A new DIVU `0xFFFF_FFFF` / 1 then completes with `{0, 0xFFFF_FFFF}`.
- **Reset mid-operation and operand stability**:
  - Pulse `rst` at iteration 20 → all outputs 0 on the next edge and state IDLE.
  - Separately, change `opdata1_i`/`opdata2_i` every cycle during ON → result still matches the operands latched at acceptance.
- **Stall handshake**: check `stall_o`=1 from the start cycle through cycle 32, and 0 in the `ready_o` cycle. Also check that `start_i` asserted during END with no drop produces no second computation.
